// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: PC, imem request/ready handshake, stalls, redirects.
// Optional interrupt entry is compiled in when IF_INTERRUPT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0010,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_sel,
  input  logic        pcr_take,
  input  logic [31:0] branch_pc,
  input  logic        reti,
  input  logic        irq,
  output logic        irq_ack,
  output logic        imem_rd,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [31:0] pc_plus_4,
  output logic        interrupt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] hold_r, hold_s;
  logic        rd_s;
  logic [31:0] addr_s;
  logic [31:0] instr_s, pp4_s;
  logic        int_s, ack_s;
  logic        redirect_s, irq_take_s, take_s, deliver_s;
  logic [31:0] word_s, word_pp4_s;

`ifdef IF_INTERRUPT_EN
  logic int_active_r, int_active_s;

  // Interrupt is eligible only on a clean accepted response with no competing redirect.
  always_comb begin
    irq_take_s = irq & ~int_active_r & ~stall & ~redirect_s;
  end

  // Nesting guard: set on entry, cleared by an unstalled return-from-interrupt.
  always_comb begin
    if (take_s) begin
      int_active_s = 1'b1;
    end else if (reti & ~stall) begin
      int_active_s = 1'b0;
    end else begin
      int_active_s = int_active_r;
    end
  end

  // Interrupt-active flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_active_r <= 1'b0;
    end else begin
      int_active_r <= int_active_s;
    end
  end
`else
  logic unused_irq_s;

  // Interrupt inputs are not used in this build.
  always_comb begin
    irq_take_s   = 1'b0;
    unused_irq_s = irq ^ reti;
  end
`endif

  // Next-state, fetch request and IF/ID contents.
  always_comb begin
    redirect_s = (branch_sel | pcr_take) & ~stall;
    state_s    = state_r;
    pc_s       = pc_r;
    hold_s     = hold_r;
    rd_s       = imem_rd;
    addr_s     = imem_addr;
    take_s     = 1'b0;
    deliver_s  = 1'b0;
    word_s     = imem_data;
    word_pp4_s = imem_addr + 32'd4;

    case (state_r)
      IDLE: begin
        state_s = REQ;
        rd_s    = 1'b1;
        if (redirect_s) begin
          pc_s   = branch_pc;
          addr_s = branch_pc;
        end else begin
          addr_s = pc_r;
        end
      end
      REQ: begin
        if (imem_rdy) begin
          if (redirect_s) begin
            pc_s   = branch_pc;
            addr_s = branch_pc;
          end else if (stall) begin
            hold_s  = imem_data;
            pc_s    = imem_addr + 32'd4;
            rd_s    = 1'b0;
            state_s = HOLD;
          end else if (irq_take_s) begin
            take_s = 1'b1;
            pc_s   = INT_VECTOR;
            addr_s = INT_VECTOR;
          end else begin
            deliver_s  = 1'b1;
            word_s     = imem_data;
            word_pp4_s = imem_addr + 32'd4;
            pc_s       = imem_addr + 32'd4;
            addr_s     = imem_addr + 32'd4;
          end
        end else if (redirect_s) begin
          // Request must complete at the old address; remember the target.
          pc_s    = branch_pc;
          state_s = DRAIN;
        end else begin
          state_s = REQ;
        end
      end
      DRAIN: begin
        if (redirect_s) begin
          pc_s = branch_pc;
        end else begin
          pc_s = pc_r;
        end
        if (imem_rdy) begin
          state_s = REQ;
          addr_s  = redirect_s ? branch_pc : pc_r;
        end else begin
          state_s = DRAIN;
        end
      end
      HOLD: begin
        if (stall) begin
          state_s = HOLD;
        end else begin
          state_s = REQ;
          rd_s    = 1'b1;
          if (redirect_s) begin
            pc_s   = branch_pc;
            addr_s = branch_pc;
          end else begin
            deliver_s  = 1'b1;
            word_s     = hold_r;
            word_pp4_s = pc_r;
            addr_s     = pc_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
        rd_s    = 1'b0;
      end
    endcase

    if (deliver_s) begin
      instr_s = word_s;
      pp4_s   = word_pp4_s;
      int_s   = 1'b0;
    end else if (take_s) begin
      instr_s = NOP_INSTR;
      pp4_s   = imem_addr;
      int_s   = 1'b1;
    end else if (stall) begin
      instr_s = instr;
      pp4_s   = pc_plus_4;
      int_s   = interrupt;
    end else begin
      instr_s = NOP_INSTR;
      pp4_s   = pc_plus_4;
      int_s   = 1'b0;
    end
    ack_s = take_s;
  end

  // State, PC, held word and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      pc_r      <= RESET_PC;
      hold_r    <= 32'h0000_0000;
      imem_rd   <= 1'b0;
      imem_addr <= 32'h0000_0000;
      instr     <= NOP_INSTR;
      pc_plus_4 <= 32'h0000_0000;
      interrupt <= 1'b0;
      irq_ack   <= 1'b0;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      hold_r    <= hold_s;
      imem_rd   <= rd_s;
      imem_addr <= addr_s;
      instr     <= instr_s;
      pc_plus_4 <= pp4_s;
      interrupt <= int_s;
      irq_ack   <= ack_s;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stimulus against a
// behavioural model of the fetch stream (sequential PC, redirects, wait states, stalls, interrupts).
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] INT_VECTOR = 32'h0000_0010;
  localparam logic [31:0] NOP        = 32'h0000_0000;
`ifdef IF_INTERRUPT_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, branch_sel, pcr_take, reti, irq, imem_rdy;
  logic [31:0] branch_pc, imem_data;
  logic        irq_ack, imem_rd, interrupt;
  logic [31:0] imem_addr, instr, pc_plus_4;

  int n_checks = 0;
  int n_pass   = 0;

  // model of architectural state and expected outputs
  logic [31:0] m_pc, m_addr, m_instr, m_pp4, m_hold;
  logic        m_rd, m_int, m_ack, m_int_active;
  logic        m_fresh, m_held, m_discard, m_deliver;

  fetch_stage #(.RESET_PC(RESET_PC), .INT_VECTOR(INT_VECTOR), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_sel(branch_sel), .pcr_take(pcr_take),
    .branch_pc(branch_pc), .reti(reti), .irq(irq), .irq_ack(irq_ack), .imem_rd(imem_rd),
    .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_data(imem_data), .instr(instr),
    .pc_plus_4(pc_plus_4), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  // program image: distinct, never equal to the bubble encoding
  function automatic logic [31:0] mem(input logic [31:0] a);
    return ((a * 32'h9E37_79B9) ^ 32'h1357_9BDF) | 32'h0000_0001;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_step();
    logic        redir, take, dlv;
    logic [31:0] w, wp;
    take = 1'b0; dlv = 1'b0; w = 32'h0; wp = 32'h0;
    redir = (branch_sel | pcr_take) & ~stall;
    if (rst) begin
      m_pc = RESET_PC; m_rd = 1'b0; m_addr = 32'h0; m_instr = NOP; m_pp4 = 32'h0;
      m_int = 1'b0; m_ack = 1'b0; m_int_active = 1'b0; m_hold = 32'h0;
      m_fresh = 1'b1; m_held = 1'b0; m_discard = 1'b0; m_deliver = 1'b0;
      return;
    end
    if (m_fresh) begin
      m_fresh = 1'b0;
      if (redir) m_pc = branch_pc;
      m_rd = 1'b1; m_addr = m_pc;
    end else if (m_held) begin
      if (!stall) begin
        m_held = 1'b0; m_rd = 1'b1;
        if (redir) m_pc = branch_pc;
        else begin dlv = 1'b1; w = m_hold; wp = m_pc; end
        m_addr = m_pc;
      end
    end else if (m_discard) begin
      if (redir) m_pc = branch_pc;
      if (imem_rdy) begin m_discard = 1'b0; m_addr = m_pc; end
    end else if (imem_rdy) begin
      if (redir) begin
        m_pc = branch_pc; m_addr = branch_pc;
      end else if (stall) begin
        m_hold = imem_data; m_pc = m_addr + 32'd4; m_rd = 1'b0; m_held = 1'b1;
      end else if (IRQ_EN && irq && !m_int_active) begin
        take = 1'b1; m_instr = NOP; m_pp4 = m_addr; m_int = 1'b1; m_int_active = 1'b1;
        m_pc = INT_VECTOR; m_addr = INT_VECTOR;
      end else begin
        dlv = 1'b1; w = imem_data; wp = m_addr + 32'd4; m_pc = wp; m_addr = wp;
      end
    end else if (redir) begin
      m_pc = branch_pc; m_discard = 1'b1;
    end
    m_ack = take;
    if (dlv) begin m_instr = w; m_pp4 = wp; m_int = 1'b0; end
    else if (!take && !stall) begin m_instr = NOP; m_int = 1'b0; end
    if (!take && reti && !stall) m_int_active = 1'b0;
    m_deliver = dlv;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("imem_rd", {31'd0, imem_rd}, {31'd0, m_rd});
    check("imem_addr", imem_addr, m_addr);
    check("instr", instr, m_instr);
    check("pc_plus_4", pc_plus_4, m_pp4);
    check("interrupt", {31'd0, interrupt}, {31'd0, m_int});
    check("irq_ack", {31'd0, irq_ack}, {31'd0, m_ack});
    if (m_deliver) check("stream", instr, mem(m_pp4 - 32'd4));
  endtask

  task automatic quiet();
    rst = 1'b0; stall = 1'b0; branch_sel = 1'b0; pcr_take = 1'b0; reti = 1'b0; irq = 1'b0;
    imem_rdy = 1'b0; imem_data = 32'hDEAD_BEEF; branch_pc = 32'h0;
  endtask

  initial begin
    logic prev_rst;
    quiet();
    // reset state
    rst = 1'b1; cycle();
    check("rst_rd", {31'd0, imem_rd}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instr, NOP);
    check("rst_pp4", pc_plus_4, 32'h0);
    rst = 1'b0; cycle();
    check("t1_addr0", imem_addr, RESET_PC);
    check("t1_rd", {31'd0, imem_rd}, 32'd1);
    // zero-wait fetch of A, B
    imem_rdy = 1'b1; imem_data = mem(32'h0); cycle();
    check("t1_instrA", instr, mem(32'h0)); check("t1_pp4A", pc_plus_4, 32'h4);
    check("t1_addr4", imem_addr, 32'h4);
    imem_data = mem(32'h4); cycle();
    check("t1_instrB", instr, mem(32'h4)); check("t1_pp4B", pc_plus_4, 32'h8);
    check("t1_addr8", imem_addr, 32'h8);
    // wait states at 8
    imem_rdy = 1'b0; cycle();
    check("t2_bubble1", instr, NOP); check("t2_addr8a", imem_addr, 32'h8);
    cycle();
    check("t2_bubble2", instr, NOP); check("t2_addr8b", imem_addr, 32'h8);
    imem_rdy = 1'b1; imem_data = mem(32'h8); cycle();
    check("t2_instrC", instr, mem(32'h8)); check("t2_pp4C", pc_plus_4, 32'hC);
    // stall as word at 0xC returns
    stall = 1'b1; imem_data = mem(32'hC); cycle();
    check("t4_rd0", {31'd0, imem_rd}, 32'd0); check("t4_frozen", instr, mem(32'h8));
    imem_rdy = 1'b0; cycle();
    check("t4_frozen_pp4", pc_plus_4, 32'hC);
    stall = 1'b0; cycle();
    check("t4_release", instr, mem(32'hC)); check("t4_pp4", pc_plus_4, 32'h10);
    check("t4_addr", imem_addr, 32'h10);
    // redirect while waiting -> drain
    branch_sel = 1'b1; branch_pc = 32'h100; cycle();
    check("t3_addr_held", imem_addr, 32'h10);
    branch_sel = 1'b0; imem_rdy = 1'b1; imem_data = mem(32'h10); cycle();
    check("t3_dropped", instr, NOP); check("t3_target", imem_addr, 32'h100);
    imem_data = mem(32'h100); cycle();
    check("t3_instr", instr, mem(32'h100)); check("t3_pp4", pc_plus_4, 32'h104);
    // address wrap
    branch_sel = 1'b1; branch_pc = 32'hFFFF_FFFC; imem_data = mem(32'h104); cycle();
    check("wrap_target", imem_addr, 32'hFFFF_FFFC);
    branch_sel = 1'b0; imem_data = mem(32'hFFFF_FFFC); cycle();
    check("wrap_pp4", pc_plus_4, 32'h0); check("wrap_addr", imem_addr, 32'h0);
    pcr_take = 1'b1; branch_pc = 32'h20; imem_data = mem(32'h0); cycle();
    check("pcr_target", imem_addr, 32'h20);
    pcr_take = 1'b0;
`ifdef IF_INTERRUPT_EN
    irq = 1'b1; imem_data = mem(32'h20); cycle();
    check("t5_ack", {31'd0, irq_ack}, 32'd1); check("t5_int", {31'd0, interrupt}, 32'd1);
    check("t5_ret", pc_plus_4, 32'h20); check("t5_vec", imem_addr, INT_VECTOR);
    imem_data = mem(INT_VECTOR); cycle();
    check("t5_no_retake", {31'd0, irq_ack}, 32'd0); check("t5_handler", instr, mem(INT_VECTOR));
    reti = 1'b1; imem_rdy = 1'b0; cycle();
    reti = 1'b0; imem_rdy = 1'b1; imem_data = mem(32'h14); cycle();
    check("t5_retake", {31'd0, irq_ack}, 32'd1); check("t5_ret2", pc_plus_4, 32'h14);
    irq = 1'b0; reti = 1'b1; imem_rdy = 1'b0; cycle();
    reti = 1'b0;
`else
    irq = 1'b1; imem_data = mem(32'h20); cycle();
    check("t5_no_ack", {31'd0, irq_ack}, 32'd0); check("t5_no_int", {31'd0, interrupt}, 32'd0);
    check("t5_normal", instr, mem(32'h20));
    irq = 1'b0;
`endif
    // reset during drain
    imem_rdy = 1'b0; branch_sel = 1'b1; branch_pc = 32'h200; cycle();
    branch_sel = 1'b0; rst = 1'b1; cycle();
    check("t6_rd", {31'd0, imem_rd}, 32'd0); check("t6_addr", imem_addr, 32'h0);
    check("t6_instr", instr, NOP); check("t6_pp4", pc_plus_4, 32'h0);
    rst = 1'b0; cycle();
    check("t6_restart", imem_addr, RESET_PC);

    // randomized traffic against the model
    prev_rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      branch_sel = !prev_rst && ($urandom_range(0, 11) == 0);
      pcr_take   = !prev_rst && ($urandom_range(0, 24) == 0);
      branch_pc  = $urandom & 32'hFFFF_FFFC;
      irq        = ($urandom_range(0, 5) == 0);
      reti       = ($urandom_range(0, 9) == 0);
      imem_rdy   = ($urandom_range(0, 9) < 6);
      imem_data  = imem_rdy ? mem(imem_addr) : $urandom;
      prev_rst   = rst;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
